// File: rtl/stim_pkg.sv
// Shared definitions for the stimulation command path.
// Command, error and mode codes are also used by the pulse logic.
package stim_pkg;

   localparam int DEF_CLK_PER_US = 50;
   localparam int DEF_TIMEOUT_US = 1000;

   localparam logic [15:0] PF_MAX  = 16'd100;
   localparam logic [15:0] BF_MAX  = 16'd4095;
   localparam logic [23:0] ONT_MAX = 24'd10000;

   localparam logic [7:0] HDR0_BYTE = 8'hAA;
   localparam logic [7:0] HDR1_BYTE = 8'h55;

   localparam logic [7:0] CMD_MODE = 8'h01;
   localparam logic [7:0] CMD_BF   = 8'h02;
   localparam logic [7:0] CMD_PF   = 8'h03;
   localparam logic [7:0] CMD_ONT  = 8'h04;
   localparam logic [7:0] CMD_RUN  = 8'h05;
   localparam logic [7:0] CMD_STOP = 8'h06;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_CHK   = 3'd1;
   localparam logic [2:0] ERR_CMD   = 3'd2;
   localparam logic [2:0] ERR_LEN   = 3'd3;
   localparam logic [2:0] ERR_RANGE = 3'd4;
   localparam logic [2:0] ERR_MODE  = 3'd5;
   localparam logic [2:0] ERR_TMO   = 3'd6;

   typedef enum logic [3:0] {
      MODE_OFF    = 4'd0,
      MODE_SINGLE = 4'd1,
      MODE_RTMS   = 4'd2,
      MODE_TBS    = 4'd3,
      MODE_TEST   = 4'd4
   } mode_e;

   typedef enum logic [2:0] {
      HDR0, HDR1, CMD, LEN, PAY, CHK, EXEC
   } state_e;

   function automatic logic [7:0] exp_len(input logic [7:0] cmd);
      case (cmd)
         CMD_MODE: exp_len = 8'd1;
         CMD_BF:   exp_len = 8'd2;
         CMD_PF:   exp_len = 8'd2;
         CMD_ONT:  exp_len = 8'd3;
         default:  exp_len = 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/us_tick_gen.sv
// One-cycle strobe every CLK_PER_US clocks; clr_i restarts the period.
// Kept standalone so the pulse logic can share it.
module us_tick_gen #(
   parameter int CLK_PER_US = 50
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

   logic [CW-1:0] cnt_q;

   assign tick_o = !clr_i && (cnt_q == LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/stim_cmd_parser.sv
// Framed UART command decoder driving the stimulation parameters.
// Values commit only in EXEC, after the whole frame has been checked.
module stim_cmd_parser
   import stim_pkg::*;
#(
   parameter int CLK_PER_US = DEF_CLK_PER_US,
   parameter int TIMEOUT_US = DEF_TIMEOUT_US
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [3:0]  stimulate_mod,
   output logic [11:0] burst_frequency,
   output logic [11:0] pulses_frequency,
   output logic [23:0] igbt_on_time,
   output logic        stim_run,
   output logic        frame_ok,
   output logic        frame_err,
   output logic [2:0]  err_code
);

   localparam int IW = $clog2(TIMEOUT_US + 1);
   localparam logic [IW-1:0] TMO = IW'(TIMEOUT_US);

   state_e      state_q;
   logic [7:0]  cmd_q;
   logic [7:0]  len_q;
   logic [7:0]  idx_q;
   logic [7:0]  sum_q;
   logic [23:0] pay_q;
   logic        chk_bad_q;
   logic [IW-1:0] idle_q;

   logic [3:0]  mode_q;
   logic [11:0] bf_q;
   logic [11:0] pf_q;
   logic [23:0] ont_q;
   logic        run_q;
   logic        ok_q;
   logic        err_q;
   logic [2:0]  ecode_q;

   logic        tick;
   logic        idle_clr;
   logic        timeout;
   logic [2:0]  verr_d;

   assign stimulate_mod    = mode_q;
   assign burst_frequency  = bf_q;
   assign pulses_frequency = pf_q;
   assign igbt_on_time     = ont_q;
   assign stim_run         = run_q;
   assign frame_ok         = ok_q;
   assign frame_err        = err_q;
   assign err_code         = ecode_q;

   // Idle time only accumulates while a frame is in progress.
   assign idle_clr = rx_valid || state_q == HDR0 || state_q == EXEC;
   assign timeout  = !idle_clr && idle_q == TMO;

   us_tick_gen #(
      .CLK_PER_US(CLK_PER_US)
   ) u_tick (
      .clk_i (sys_clk),
      .rst_ni(sys_rst_n),
      .clr_i (idle_clr),
      .tick_o(tick)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         idle_q <= '0;
      end else if (idle_clr) begin
         idle_q <= '0;
      end else if (tick && idle_q != TMO) begin
         idle_q <= idle_q + 1'b1;
      end
   end

   always_comb begin
      verr_d = ERR_NONE;
      if (chk_bad_q) begin
         verr_d = ERR_CHK;
      end else if (cmd_q == 8'h00 || cmd_q > CMD_STOP) begin
         verr_d = ERR_CMD;
      end else if (len_q != exp_len(cmd_q)) begin
         verr_d = ERR_LEN;
      end else begin
         case (cmd_q)
            CMD_MODE:
               if (pay_q[7:0] > 8'd4) verr_d = ERR_RANGE;
            CMD_BF:
               if (pay_q[15:0] == 16'd0 || pay_q[15:0] > BF_MAX)
                  verr_d = ERR_RANGE;
            CMD_PF:
               if (pay_q[15:0] == 16'd0 || pay_q[15:0] > PF_MAX)
                  verr_d = ERR_RANGE;
            CMD_ONT:
               if (pay_q == 24'd0 || pay_q > ONT_MAX)
                  verr_d = ERR_RANGE;
            CMD_RUN:
               if (mode_q == MODE_OFF) verr_d = ERR_MODE;
            default: verr_d = ERR_NONE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= HDR0;
         cmd_q     <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         sum_q     <= '0;
         pay_q     <= '0;
         chk_bad_q <= 1'b0;
         mode_q    <= MODE_OFF;
         bf_q      <= 12'd0;
         pf_q      <= 12'd1;
         ont_q     <= 24'd100;
         run_q     <= 1'b0;
         ok_q      <= 1'b0;
         err_q     <= 1'b0;
         ecode_q   <= ERR_NONE;
      end else begin
         ok_q  <= 1'b0;
         err_q <= 1'b0;
         if (timeout) begin
            state_q <= HDR0;
            err_q   <= 1'b1;
            ecode_q <= ERR_TMO;
         end else if (state_q == EXEC) begin
            state_q <= HDR0;
            if (verr_d == ERR_NONE) begin
               ok_q <= 1'b1;
               case (cmd_q)
                  CMD_MODE: begin
                     mode_q <= pay_q[3:0];
                     run_q  <= 1'b0;
                  end
                  CMD_BF: begin
                     bf_q  <= pay_q[11:0];
                     run_q <= 1'b0;
                  end
                  CMD_PF: begin
                     pf_q  <= pay_q[11:0];
                     run_q <= 1'b0;
                  end
                  CMD_ONT: begin
                     ont_q <= pay_q;
                     run_q <= 1'b0;
                  end
                  CMD_RUN: run_q <= 1'b1;
                  default: run_q <= 1'b0;
               endcase
            end else begin
               err_q   <= 1'b1;
               ecode_q <= verr_d;
            end
         end else if (rx_valid) begin
            unique case (state_q)
               HDR0:
                  if (rx_data == HDR0_BYTE) state_q <= HDR1;
               HDR1:
                  if (rx_data == HDR1_BYTE) state_q <= CMD;
                  else if (rx_data != HDR0_BYTE) state_q <= HDR0;
               CMD: begin
                  cmd_q   <= rx_data;
                  sum_q   <= rx_data;
                  state_q <= LEN;
               end
               LEN: begin
                  len_q   <= rx_data;
                  sum_q   <= sum_q + rx_data;
                  pay_q   <= '0;
                  idx_q   <= '0;
                  state_q <= (rx_data == 8'd0) ? CHK : PAY;
               end
               PAY: begin
                  pay_q <= {pay_q[15:0], rx_data};
                  sum_q <= sum_q + rx_data;
                  idx_q <= idx_q + 8'd1;
                  if (idx_q == len_q - 8'd1) state_q <= CHK;
               end
               CHK: begin
                  chk_bad_q <= (rx_data != sum_q);
                  state_q   <= EXEC;
               end
               default: state_q <= HDR0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stim_cmd_parser.sv
// Directed bench for stim_cmd_parser: frames, rejections, timeout, reset.
// Expected values are hand-computed from the frame contents.
module tb_stim_cmd_parser;

   typedef logic [7:0] bq_t[$];

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [3:0]  mode;
   logic [11:0] bf;
   logic [11:0] pf;
   logic [23:0] ont;
   logic        run;
   logic        ok;
   logic        err;
   logic [2:0]  ecode;

   int n_pass = 0;
   int n_tot  = 0;

   stim_cmd_parser dut (
      .sys_clk         (clk),
      .sys_rst_n       (rst_n),
      .rx_data         (rx_data),
      .rx_valid        (rx_valid),
      .stimulate_mod   (mode),
      .burst_frequency (bf),
      .pulses_frequency(pf),
      .igbt_on_time    (ont),
      .stim_run        (run),
      .frame_ok        (ok),
      .frame_err       (err),
      .err_code        (ecode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input bq_t f);
      foreach (f[i]) send_byte(f[i]);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      n_tot++;
      if ({mode, bf, pf, ont, run, ok, err, ecode} !==
          {4'd0, 12'd0, 12'd1, 24'd100, 1'b0, 1'b0, 1'b0, 3'd0})
         $display("FAIL reset: mode=%0d bf=%0d pf=%0d ont=%0d run=%b ok=%b err=%b ec=%0d",
                  mode, bf, pf, ont, run, ok, err, ecode);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mode;
      bq_t f = '{8'hAA, 8'h55, 8'h01, 8'h01, 8'h03, 8'h05};
      foreach (f[i]) send_byte(f[i]);
      n_tot++;
      if (ok !== 1'b0 || mode !== 4'd0)
         $display("FAIL mode_latency: ok=%b mode=%0d required ok=0 mode=0", ok, mode);
      else n_pass++;
      @(posedge clk);
      #1;
      n_tot++;
      if (ok !== 1'b1 || err !== 1'b0 || mode !== 4'd3 || ecode !== 3'd0)
         $display("FAIL mode_commit: ok=%b err=%b mode=%0d ec=%0d required 1 0 3 0",
                  ok, err, mode, ecode);
      else n_pass++;
      @(posedge clk);
      #1;
      n_tot++;
      if (ok !== 1'b0)
         $display("FAIL ok_pulse_width: ok=%b required 0", ok);
      else n_pass++;
   endtask

   task automatic test_ontime_run;
      send_frame('{8'hAA, 8'h55, 8'h04, 8'h03, 8'h00, 8'h01, 8'hF4, 8'hFC});
      n_tot++;
      if (ok !== 1'b1 || ont !== 24'd500)
         $display("FAIL ontime: ok=%b ont=%0d required ok=1 ont=500", ok, ont);
      else n_pass++;
      send_frame('{8'hAA, 8'h55, 8'h05, 8'h00, 8'h05});
      n_tot++;
      if (ok !== 1'b1 || run !== 1'b1)
         $display("FAIL run: ok=%b run=%b required 1 1", ok, run);
      else n_pass++;
   endtask

   task automatic test_range;
      send_frame('{8'hAA, 8'h55, 8'h03, 8'h02, 8'h00, 8'h65, 8'h6A});
      n_tot++;
      if (err !== 1'b1 || ok !== 1'b0 || ecode !== 3'd4 || pf !== 12'd1 || run !== 1'b1)
         $display("FAIL pf_range: err=%b ok=%b ec=%0d pf=%0d run=%b required 1 0 4 1 1",
                  err, ok, ecode, pf, run);
      else n_pass++;
   endtask

   task automatic test_chk_and_stop;
      send_frame('{8'hAA, 8'h55, 8'h01, 8'h01, 8'h02, 8'h00});
      n_tot++;
      if (err !== 1'b1 || ecode !== 3'd1 || mode !== 4'd3)
         $display("FAIL bad_chk: err=%b ec=%0d mode=%0d required 1 1 3", err, ecode, mode);
      else n_pass++;
      send_frame('{8'hAA, 8'hAA, 8'h55, 8'h06, 8'h00, 8'h06});
      n_tot++;
      if (ok !== 1'b1 || run !== 1'b0 || mode !== 4'd3 || ecode !== 3'd1)
         $display("FAIL stop: ok=%b run=%b mode=%0d ec=%0d required 1 0 3 1",
                  ok, run, mode, ecode);
      else n_pass++;
   endtask

   task automatic test_timeout;
      int cyc = 0;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_byte(8'h02);
      while (err !== 1'b1 && cyc < 52000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_tot++;
      if (err !== 1'b1 || ecode !== 3'd6 || cyc < 49990 || cyc > 50010)
         $display("FAIL timeout: err=%b ec=%0d cycles=%0d required 1 6 ~50001",
                  err, ecode, cyc);
      else n_pass++;
      send_frame('{8'hAA, 8'h55, 8'h02, 8'h02, 8'h01, 8'hF4, 8'hF9});
      n_tot++;
      if (ok !== 1'b1 || bf !== 12'd500)
         $display("FAIL after_timeout: ok=%b bf=%0d required 1 500", ok, bf);
      else n_pass++;
   endtask

   task automatic test_errors;
      send_frame('{8'hAA, 8'h55, 8'h07, 8'h00, 8'h07});
      n_tot++;
      if (err !== 1'b1 || ecode !== 3'd2)
         $display("FAIL bad_cmd: err=%b ec=%0d required 1 2", err, ecode);
      else n_pass++;
      send_frame('{8'hAA, 8'h55, 8'h02, 8'h01, 8'h05, 8'h08});
      n_tot++;
      if (err !== 1'b1 || ecode !== 3'd3 || bf !== 12'd500)
         $display("FAIL bad_len: err=%b ec=%0d bf=%0d required 1 3 500", err, ecode, bf);
      else n_pass++;
      send_frame('{8'hAA, 8'h55, 8'h04, 8'h04, 8'h00, 8'h00, 8'h01, 8'hF4, 8'hFD});
      n_tot++;
      if (err !== 1'b1 || ecode !== 3'd3 || ont !== 24'd500)
         $display("FAIL long_len: err=%b ec=%0d ont=%0d required 1 3 500", err, ecode, ont);
      else n_pass++;
      send_frame('{8'hAA, 8'h55, 8'h01, 8'h01, 8'h00, 8'h02});
      send_frame('{8'hAA, 8'h55, 8'h05, 8'h00, 8'h05});
      n_tot++;
      if (err !== 1'b1 || ok !== 1'b0 || ecode !== 3'd5 || run !== 1'b0 || mode !== 4'd0)
         $display("FAIL run_mode_off: err=%b ok=%b ec=%0d run=%b mode=%0d required 1 0 5 0 0",
                  err, ok, ecode, run, mode);
      else n_pass++;
      send_frame('{8'hAA, 8'h55, 8'h02, 8'h02, 8'h10, 8'h00, 8'h14});
      n_tot++;
      if (err !== 1'b1 || ecode !== 3'd4 || bf !== 12'd500)
         $display("FAIL bf_range: err=%b ec=%0d bf=%0d required 1 4 500", err, ecode, bf);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      send_byte(8'hAA);
      send_byte(8'h55);
      send_byte(8'h04);
      send_byte(8'h03);
      send_byte(8'h00);
      #3;
      rst_n = 1'b0;
      #1;
      n_tot++;
      if ({mode, bf, pf, ont, run, ecode} !==
          {4'd0, 12'd0, 12'd1, 24'd100, 1'b0, 3'd0})
         $display("FAIL reset_mid: mode=%0d bf=%0d pf=%0d ont=%0d run=%b ec=%0d",
                  mode, bf, pf, ont, run, ecode);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back;
      send_frame('{8'hAA, 8'h55, 8'h01, 8'h01, 8'h02, 8'h04});
      send_frame('{8'hAA, 8'h55, 8'h05, 8'h00, 8'h05});
      n_tot++;
      if (ok !== 1'b1 || run !== 1'b1 || mode !== 4'd2)
         $display("FAIL b2b_run: ok=%b run=%b mode=%0d required 1 1 2", ok, run, mode);
      else n_pass++;
      send_frame('{8'hAA, 8'h55, 8'h02, 8'h02, 8'h00, 8'h0A, 8'h0E});
      n_tot++;
      if (ok !== 1'b1 || err !== 1'b0 || run !== 1'b0 || bf !== 12'd10)
         $display("FAIL bf_clears_run: ok=%b err=%b run=%b bf=%0d required 1 0 0 10",
                  ok, err, run, bf);
      else n_pass++;
   endtask

   initial begin
      test_reset;
      test_mode;
      test_ontime_run;
      test_range;
      test_chk_and_stop;
      test_timeout;
      test_errors;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
